// File: rtl/timer_prog_if.sv
// Sequencer-side bundle for the programmable interval timer.
// The sequencer holds state_start and state_over_n as levels; the run enable is
// their AND and is sampled on every rising clk_sys edge. There is no per-beat
// handshake: datain, presc and mode are taken only on the edge that leaves IDLE.
// The timer answers with level outputs (done, busy, count, expiries, fsm_state)
// plus the single-cycle time_up pulse.
interface timer_prog_if #(
    parameter int WIDTH = 22,
    parameter int PW    = 8
);
    logic             work_n;
    logic             state_start;
    logic             state_over_n;
    logic [WIDTH-1:0] datain;
    logic [PW-1:0]    presc;
    logic             mode;
    logic             time_up;
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] count;
    logic [7:0]       expiries;
    logic [1:0]       fsm_state;

    modport master (
        output work_n, state_start, state_over_n, datain, presc, mode,
        input  time_up, done, busy, count, expiries, fsm_state
    );

    modport slave (
        input  work_n, state_start, state_over_n, datain, presc, mode,
        output time_up, done, busy, count, expiries, fsm_state
    );
endinterface

// File: rtl/timer_prog.sv
// Programmable interval timer for NMR sequence dwells: prescaled tick counter
// with one-shot or periodic expiry, terminal count latched at start.
module timer_prog #(
    parameter int WIDTH = 22,
    parameter int PW    = 8
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    timer_prog_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [7:0]       exp_q, exp_d;
    logic             time_up_q, time_up_d;
    logic             done_q, done_d;
    logic             en;

    assign en = bus.state_start & bus.state_over_n;

    // Register bank: async reset, then work_n as a synchronous clear.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            term_q    <= '0;
            presc_q   <= '0;
            mode_q    <= 1'b0;
            pcnt_q    <= '0;
            count_q   <= '0;
            exp_q     <= '0;
            time_up_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.work_n) begin
            state_q   <= IDLE;
            term_q    <= '0;
            presc_q   <= '0;
            mode_q    <= 1'b0;
            pcnt_q    <= '0;
            count_q   <= '0;
            exp_q     <= '0;
            time_up_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            term_q    <= term_d;
            presc_q   <= presc_d;
            mode_q    <= mode_d;
            pcnt_q    <= pcnt_d;
            count_q   <= count_d;
            exp_q     <= exp_d;
            time_up_q <= time_up_d;
            done_q    <= done_d;
        end
    end

    // Next-state and counter logic; en=0 outranks expiry, so an abort on the
    // expiry edge swallows the pulse.
    always_comb begin
        state_d   = state_q;
        term_d    = term_q;
        presc_d   = presc_q;
        mode_d    = mode_q;
        pcnt_d    = pcnt_q;
        count_d   = count_q;
        exp_d     = exp_q;
        time_up_d = 1'b0;
        done_d    = done_q;
        case (state_q)
            IDLE: begin
                pcnt_d  = '0;
                count_d = '0;
                exp_d   = '0;
                done_d  = 1'b0;
                if (en) begin
                    state_d = RUN;
                    // A terminal count of zero would never expire; treat it as one.
                    term_d  = (bus.datain == '0) ? WIDTH'(1) : bus.datain;
                    presc_d = bus.presc;
                    mode_d  = bus.mode;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                    count_d = '0;
                    exp_d   = '0;
                    done_d  = 1'b0;
                end else if (pcnt_q == presc_q) begin
                    pcnt_d = '0;
                    if (count_q == term_q - WIDTH'(1)) begin
                        time_up_d = 1'b1;
                        count_d   = '0;
                        exp_d     = exp_q + 8'd1;
                        if (!mode_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            DONE: begin
                if (!en) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                    count_d = '0;
                    exp_d   = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.time_up   = time_up_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.count     = count_q;
    assign bus.expiries  = exp_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_timer_prog.sv
// Self-checking bench for timer_prog: directed scenarios plus random runs,
// compared every cycle against an elapsed-time arithmetic model.
module tb_timer_prog;
    localparam int WIDTH = 22;
    localparam int PW    = 8;

    logic clk_sys;
    logic rst_n;

    timer_prog_if #(.WIDTH(WIDTH), .PW(PW)) bus ();

    timer_prog #(.WIDTH(WIDTH), .PW(PW)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a run is described only by its start-time offset and
    // the captured N, P, mode; all outputs follow from elapsed edges.
    bit          m_run  = 1'b0;
    longint      m_t    = 0;
    longint      m_n    = 1;
    longint      m_p    = 0;
    bit          m_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic set_in(input bit st, input bit ov, input int d, input int p, input bit m);
        bus.state_start  = st;
        bus.state_over_n = ov;
        bus.datain       = WIDTH'(d);
        bus.presc        = PW'(p);
        bus.mode         = m;
    endtask

    task automatic compare_all(input string tag);
        longint ticks;
        bit     e_tu, e_done, e_busy;
        longint e_cnt, e_exp;
        e_tu = 0; e_done = 0; e_busy = 0; e_cnt = 0; e_exp = 0;
        if (m_run) begin
            ticks = m_t / (m_p + 1);
            if (m_mode || ticks < m_n) begin
                e_busy = 1;
                e_cnt  = ticks % m_n;
                e_exp  = (ticks / m_n) % 256;
                e_tu   = (m_t > 0) && (m_t % (m_p + 1) == 0) && (ticks % m_n == 0);
            end else begin
                e_done = 1;
                e_cnt  = 0;
                e_exp  = 1;
                e_tu   = (m_t == m_n * (m_p + 1));
            end
        end
        check({tag, ".time_up"},  32'(bus.time_up),  32'(e_tu));
        check({tag, ".done"},     32'(bus.done),     32'(e_done));
        check({tag, ".busy"},     32'(bus.busy),     32'(e_busy));
        check({tag, ".count"},    32'(bus.count),    32'(e_cnt));
        check({tag, ".expiries"}, 32'(bus.expiries), 32'(e_exp));
    endtask

    // One clock edge: update the model from the inputs held across the edge,
    // then compare #1 later.
    task automatic step(input string tag);
        bit w, en;
        w  = bus.work_n;
        en = bus.state_start & bus.state_over_n;
        @(posedge clk_sys);
        if (w || !en) begin
            m_run = 0;
        end else if (!m_run) begin
            m_run  = 1;
            m_t    = 0;
            m_n    = (bus.datain == '0) ? 1 : longint'(bus.datain);
            m_p    = longint'(bus.presc);
            m_mode = bus.mode;
        end else begin
            m_t++;
        end
        #1;
        compare_all(tag);
    endtask

    initial begin
        int len, r;
        rst_n       = 1'b0;
        bus.work_n  = 1'b0;
        set_in(0, 1, 0, 0, 0);
        #12;
        compare_all("reset");
        #10 rst_n = 1'b1;   // released at t=22, away from an edge

        // One-shot N=5 P=0, en held for 60 edges.
        set_in(1, 1, 5, 0, 0);
        repeat (61) step("oneshot");
        set_in(0, 1, 5, 0, 0);
        step("oneshot_drop");

        // Periodic N=3 P=2.
        set_in(1, 1, 3, 2, 1);
        repeat (31) step("periodic");
        set_in(0, 1, 3, 2, 1);
        step("periodic_drop");

        // datain changes mid-run are ignored; restart picks up the new value.
        set_in(1, 1, 5, 0, 0);
        repeat (3) step("sample");
        set_in(1, 1, 2, 0, 0);
        repeat (6) step("sample_hold");
        set_in(0, 1, 2, 0, 0);
        step("sample_drop");
        set_in(1, 1, 2, 0, 0);
        repeat (5) step("sample_new");
        set_in(0, 1, 2, 0, 0);
        step("sample_drop2");

        // Abort exactly on the expiry edge.
        set_in(1, 1, 5, 0, 1);
        repeat (5) step("abort_pre");
        bus.state_over_n = 1'b0;
        step("abort_edge");
        check("abort_no_pulse", 32'(bus.time_up), 32'd0);
        bus.state_over_n = 1'b1;
        repeat (3) step("abort_restart");

        // work_n mid-run, then restart with en still high.
        set_in(1, 1, 7, 1, 1);
        repeat (6) step("work_pre");
        bus.work_n = 1'b1;
        step("work_clr");
        bus.work_n = 1'b0;
        repeat (4) step("work_post");

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        m_run = 0;
        #1 compare_all("async_rst");
        #3 rst_n = 1'b1;
        set_in(0, 1, 0, 0, 0);
        step("async_idle");

        // datain=0 behaves as N=1.
        set_in(1, 1, 0, 0, 1);
        repeat (10) step("zero_n");
        set_in(0, 1, 0, 0, 1);
        step("zero_drop");

        // Largest terminal count: counts up without wrapping.
        set_in(1, 1, (1 << WIDTH) - 1, 0, 0);
        repeat (300) step("max_n");
        set_in(0, 1, 0, 0, 0);
        step("max_drop");

        // Periodic N=1 for 260 edges after start: expiries wraps to 4.
        set_in(1, 1, 1, 0, 1);
        repeat (261) step("wrap");
        check("wrap_final", 32'(bus.expiries), 32'd4);
        set_in(0, 1, 0, 0, 0);
        step("wrap_drop");

        // Random runs with sporadic aborts, work_n pulses and input noise.
        for (int s = 0; s < 40; s++) begin
            set_in(1, 1, $urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            len = $urandom_range(5, 60);
            for (int c = 0; c < len; c++) begin
                r = $urandom_range(0, 99);
                bus.state_over_n = (r >= 3);
                bus.work_n       = (r == 3);
                if (r >= 90) begin
                    bus.datain = WIDTH'($urandom_range(0, 6));
                    bus.presc  = PW'($urandom_range(0, 3));
                    bus.mode   = 1'($urandom_range(0, 1));
                end
                step("rand");
            end
            bus.work_n = 1'b0;
            set_in(0, 1, 0, 0, 0);
            step("rand_drop");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
